small_hb_dec: RTL and testbench
===============================

Name: small_hb_dec

Overview:
Short 7-tap halfband decimator-by-2 with impulse response [A 0 B 0.5 B 0 A]. It is the receive-side counterpart of the short halfband interpolator and sits at the end of the DDC decimation chain, after the CIC. A single shared multiplier is time-multiplexed over the two distinct non-zero coefficients, and the 0.5 centre tap is applied as a shift. Gain is ~1.0.

Parameters:
WIDTH, 18, sample width (signed, two's complement) for data_in and data_out.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
run  in  1  low: flush the filter state and suppress output
bypass  in  1  high: pass input straight through, no decimation
stb_in  in  1  input sample strobe; minimum spacing is 2 clk cycles
data_in  in  WIDTH  input sample, signed
stb_out  out  1  single-cycle output strobe
data_out  out  WIDTH  output sample, signed; held between strobes

Behaviour:
- Reset: stb_out=0, data_out=0, phase=0, delay line d0..d6=0, accumulator=0, pipeline valid bits=0.
- Coefficients are Q1.17 (131072 = 1.0): A=-5345, B=37905. Centre tap is d3<<16. Tap sum is 130656.
- Delay line: on stb_in, d0<=data_in and dk<=d(k-1). The phase bit toggles on every stb_in.
- Compute trigger: a stb_in that arrives while phase=1 (the 2nd, 4th, ... sample after run rises). Call that cycle t.
  - t+1: outer pre-add (d0+d6) is registered, WIDTH+1 bits.
  - t+2: inner pre-add (d2+d4) is registered; multiplier forms A*outer.
  - t+3: multiplier forms B*inner.
  - t+4: acc = A*outer + (d3<<16). Use the d3 value captured at t+1.
  - t+5: acc += B*inner. The accumulator is 38 bits.
  - t+6: data_out = sat(round(acc>>17)); stb_out=1 for exactly one cycle.
- Fixed latency: stb_out fires exactly 6 cycles after the triggering stb_in.
- Operands are captured at t+1, so a new stb_in at t+2 (minimum spacing) does not disturb the computation in flight.
- Rounding: add 2^16, then arithmetic shift right 17 (round half up).
- Saturation: clip to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Back-to-back stb_in (spacing 1) is a protocol violation. Output values are unspecified, but the block must return to correct operation after 7 legally spaced samples. No lock-up.
- run=0: the same-cycle clear of phase, delay line, in-flight valid bits and stb_out takes priority over stb_in. data_out holds its last value. After run rises, the first output is triggered by the 2nd accepted sample.
- bypass=1: data_out<=data_in and stb_out<=stb_in, registered with 1-cycle latency. The decimation pipeline is held cleared.
- bypass or run change mid-computation: the in-flight result is discarded; no stb_out is generated for it.
- rst mid-operation: full return to reset values on the next edge.

Decomposition:
- Package small_hb_pkg: COEFF_A, COEFF_B, COEFF_FRAC=17, CENTER_SHIFT=16, LATENCY=6, and the accumulator width function (2*WIDTH+2).
- One sub-module, hb_dec_mac: holds the shared 18x18 signed multiplier and the accumulator with clear/accumulate controls, plus the round-and-saturate output stage.
- The top level owns the delay line, phase bit, pre-adders and the control shift register.

Test Plan:
- Impulse on an odd slot: run=1; samples 0,65536,0,0,0,... at spacing 2 -> outputs -2672, 18953, 18953, -2672, then 0. Each stb_out is 6 cycles after its trigger.
- Impulse on an even slot: samples 65536,0,0,... -> outputs 0, 32768, 0, 0.
- DC gain: constant 10000 -> after 4 outputs, steady 9968. Constant -131072 -> steady -130656.
- Saturation: pattern giving d0=d6=-131072 and d2=d3=d4=131071 at a trigger -> data_out=131071. Also check the negative mirror -> -131072.
- Control: run dropped mid-computation -> no stb_out and the state is zero. Bypass=1 with data_in=1234 strobed -> data_out=1234 and stb_out one cycle later, on every sample.
- Robustness: inject one back-to-back stb_in pair, then legal traffic with constant 10000 -> output returns to 9968 within 4 outputs. Assert rst mid-run -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/small_hb_pkg.sv
// Shared constants for the short halfband decimator: Q1.17 coefficients,
// rounding position, centre-tap shift, pipeline latency and accumulator sizing.
// No logic; imported by small_hb_dec and hb_dec_mac.
package small_hb_pkg;

    localparam int COEFF_W = 18;

    // Q1.17 (131072 = 1.0); outer taps A, inner taps B, centre 0.5 via shift.
    localparam logic signed [COEFF_W-1:0] COEFF_A = -18'sd5345;
    localparam logic signed [COEFF_W-1:0] COEFF_B = 18'sd37905;

    localparam int COEFF_FRAC   = 17;
    localparam int CENTER_SHIFT = 16;

    // Cycles from the triggering stb_in to stb_out.
    localparam int LATENCY = 6;

    // Accumulator width for a given sample width.
    function automatic int acc_width(input int width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/hb_dec_mac.sv
// Shared multiplier + accumulator with combinational round/saturate result.
// Latency: product registered 1 cycle after mul_a/mul_b; result follows acc.
// No backpressure: controls come from the parent's fixed-timing shift register.
// Ports: clr flushes product/acc; mul_a forms A*outer, mul_b forms B*inner;
//        acc_load sets acc = product + (center<<16); acc_add adds product;
//        result = sat(round(acc >> 17)) to WIDTH bits.
module hb_dec_mac
    import small_hb_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    mul_a,
    input  logic                    mul_b,
    input  logic                    acc_load,
    input  logic                    acc_add,
    input  logic signed [WIDTH:0]   outer,
    input  logic signed [WIDTH:0]   inner,
    input  logic signed [WIDTH-1:0] center,
    output logic signed [WIDTH-1:0] result
);

    localparam int PW = WIDTH + 1 + COEFF_W;
    localparam int AW = acc_width(WIDTH);

    localparam logic signed [AW-1:0] RND_BIAS = AW'(64'sd1 <<< (COEFF_FRAC - 1));
    localparam logic signed [AW-1:0] SAT_MAX  = AW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN  = AW'(-(64'sd1 <<< (WIDTH - 1)));

    logic signed [WIDTH:0]     mul_op;
    logic signed [COEFF_W-1:0] mul_coef;
    logic signed [PW-1:0]      prod_nxt;
    logic signed [PW-1:0]      prod_r;
    logic signed [AW-1:0]      prod_ext;
    logic signed [AW-1:0]      center_ext;
    logic signed [AW-1:0]      acc_r;
    logic signed [AW-1:0]      rnd_sum;
    logic signed [AW-1:0]      shifted;

    // If both selects are ever high together (illegal strobe spacing) the
    // inner operand wins; the result is garbage but the pipe keeps moving.
    always_comb begin
        mul_op   = outer;
        mul_coef = COEFF_A;
        if (mul_b) begin
            mul_op   = inner;
            mul_coef = COEFF_B;
        end
    end

    assign prod_nxt   = mul_op * mul_coef;
    assign prod_ext   = AW'(prod_r);
    assign center_ext = AW'(center) <<< CENTER_SHIFT;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prod_r <= '0;
            acc_r  <= '0;
        end else begin
            if (mul_a || mul_b) begin
                prod_r <= prod_nxt;
            end
            if (acc_load) begin
                acc_r <= prod_ext + center_ext;
            end else if (acc_add) begin
                acc_r <= acc_r + prod_ext;
            end
        end
    end

    // Round half up, then clip to the signed WIDTH range.
    assign rnd_sum = acc_r + RND_BIAS;
    assign shifted = rnd_sum >>> COEFF_FRAC;

    always_comb begin
        result = shifted[WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/small_hb_dec.sv
// 7-tap halfband decimate-by-2 [A 0 B 0.5 B 0 A] with one shared multiplier.
// Latency: stb_out 6 cycles after the triggering (every 2nd) stb_in; bypass 1 cycle.
// No backpressure: stb_in must be spaced >= 2 cycles; run=0 or bypass flushes state.
// Ports: clk, rst (sync, active-high), run, bypass, stb_in, data_in[WIDTH],
//        stb_out (1-cycle pulse), data_out[WIDTH] (held between strobes).
module small_hb_dec
    import small_hb_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic                    bypass,
    input  logic                    stb_in,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    stb_out,
    output logic signed [WIDTH-1:0] data_out
);

    localparam int NTAP = 7;
    localparam int VW   = LATENCY - 1;

    logic signed [WIDTH-1:0] dly [NTAP];
    logic                    phase;
    // vld[k] is high in cycle t+1+k after a trigger at cycle t.
    logic [VW-1:0]           vld;
    logic signed [WIDTH:0]   outer_r;
    logic signed [WIDTH:0]   inner_r;
    logic signed [WIDTH-1:0] center_r;
    logic signed [WIDTH-1:0] mac_result;

    logic flush;
    logic trig;

    assign flush = !run || bypass;
    assign trig  = stb_in && phase;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            phase    <= 1'b0;
            vld      <= '0;
            outer_r  <= '0;
            inner_r  <= '0;
            center_r <= '0;
            for (int k = 0; k < NTAP; k++) begin
                dly[k] <= '0;
            end
        end else begin
            if (stb_in) begin
                dly[0] <= data_in;
                for (int k = 1; k < NTAP; k++) begin
                    dly[k] <= dly[k-1];
                end
                phase <= !phase;
            end
            vld <= {vld[VW-2:0], trig};
            // Outer sum and centre tap are captured before the next strobe
            // (earliest at t+2) can shift the delay line.
            if (vld[0]) begin
                outer_r  <= {dly[0][WIDTH-1], dly[0]} + {dly[6][WIDTH-1], dly[6]};
                center_r <= dly[3];
            end
            // Registered on the edge that the next strobe would shift on, so
            // it still sees the pre-shift d2/d4.
            if (vld[1]) begin
                inner_r <= {dly[2][WIDTH-1], dly[2]} + {dly[4][WIDTH-1], dly[4]};
            end
        end
    end

    hb_dec_mac #(
        .WIDTH (WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .mul_a    (vld[1]),
        .mul_b    (vld[2]),
        .acc_load (vld[2]),
        .acc_add  (vld[3]),
        .outer    (outer_r),
        .inner    (inner_r),
        .center   (center_r),
        .result   (mac_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stb_out  <= 1'b0;
            data_out <= '0;
        end else if (!run) begin
            stb_out <= 1'b0;
        end else if (bypass) begin
            stb_out <= stb_in;
            if (stb_in) begin
                data_out <= data_in;
            end
        end else begin
            stb_out <= vld[VW-1];
            if (vld[VW-1]) begin
                data_out <= mac_result;
            end
        end
    end

endmodule

// File: tb/tb_small_hb_dec.sv
// Self-checking bench for small_hb_dec: directed and randomized strobes
// checked cycle by cycle against a direct-convolution reference model.
module tb_small_hb_dec;

    localparam int W = 18;
    localparam longint CA = -5345;
    localparam longint CB = 37905;

    logic                clk = 1'b0;
    logic                rst;
    logic                run;
    logic                bypass;
    logic                stb_in;
    logic signed [W-1:0] data_in;
    logic                stb_out;
    logic signed [W-1:0] data_out;

    small_hb_dec #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .bypass   (bypass),
        .stb_in   (stb_in),
        .data_in  (data_in),
        .stb_out  (stb_out),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint due;
        int     val;
        bit     dc;
    } ev_t;

    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    int     hist[$];
    int     n_acc = 0;
    ev_t    pend[$];
    bit     exp_stb = 1'b0;
    int     exp_dout = 0;
    bit     dout_known = 1'b0;
    longint last_stb_cyc = -10;
    int     dc_cnt = 0;
    int     got[$];

    // y = sum h[k]*x[n-k] with h = [A 0 B 0.5 B 0 A], round half up, clip.
    function automatic int ref_out();
        longint xs[7];
        longint acc;
        longint y;
        for (int k = 0; k < 7; k++) begin
            xs[k] = (k < hist.size()) ? longint'(hist[k]) : 64'sd0;
        end
        acc = CA * (xs[0] + xs[6]) + CB * (xs[2] + xs[4]) + xs[3] * 65536;
        y = (acc + 65536) >>> 17;
        if (y > 131071) y = 131071;
        if (y < -131072) y = -131072;
        return int'(y);
    endfunction

    task automatic clear_state();
        hist.delete();
        pend.delete();
        n_acc = 0;
        dc_cnt = 0;
        last_stb_cyc = -10;
    endtask

    task automatic model_edge(input bit s, input int x);
        ev_t e;
        bit  viol;
        exp_stb = 1'b0;
        if (rst) begin
            clear_state();
            exp_dout = 0;
            dout_known = 1'b1;
        end else if (!run) begin
            clear_state();
        end else if (bypass) begin
            clear_state();
            if (s) begin
                exp_stb = 1'b1;
                exp_dout = x;
                dout_known = 1'b1;
            end
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e = pend.pop_front();
                exp_stb = 1'b1;
                if (e.dc) dout_known = 1'b0;
                else begin
                    exp_dout = e.val;
                    dout_known = 1'b1;
                end
            end
            if (s) begin
                viol = (last_stb_cyc == cyc - 1);
                e.dc = viol || (dc_cnt > 0);
                if (viol) dc_cnt = 7;
                else if (dc_cnt > 0) dc_cnt--;
                last_stb_cyc = cyc;
                hist.push_front(x);
                if (hist.size() > 7) void'(hist.pop_back());
                n_acc++;
                if (n_acc % 2 == 0) begin
                    e.due = cyc + 5;
                    e.val = ref_out();
                    pend.push_back(e);
                end
            end
        end
    endtask

    task automatic check(input string tag, input longint obs, input longint expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input bit s, input int x);
        stb_in = s;
        data_in = x[W-1:0];
        @(posedge clk);
        cyc++;
        model_edge(s, x);
        #1;
        check("stb_out", longint'(stb_out), longint'(exp_stb));
        if (dout_known) check("data_out", longint'(data_out), longint'(exp_dout));
        if (stb_out) got.push_back(int'(data_out));
        stb_in = 1'b0;
    endtask

    task automatic send(input int x);
        step(1'b1, x);
        step(1'b0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic restart();
        run = 1'b0;
        step(1'b0, 0);
        run = 1'b1;
        got.delete();
    endtask

    int satp[8];
    int pat_a[4];
    int pat_b[4];
    logic signed [W-1:0] r;
    int x;
    int sel;

    initial begin
        rst = 1'b1; run = 1'b0; bypass = 1'b0; stb_in = 1'b0; data_in = '0;
        idle(3);
        check("reset_stb", longint'(stb_out), 0);
        check("reset_dout", longint'(data_out), 0);
        rst = 1'b0;

        // Impulse on odd slot.
        restart();
        send(0); send(65536);
        for (int i = 0; i < 10; i++) send(0);
        idle(8);
        pat_a = '{-2672, 18953, 18953, -2672};
        check("imp_odd_cnt", got.size(), 6);
        for (int i = 0; i < 4; i++) check("imp_odd", got[i], pat_a[i]);
        check("imp_odd_tail", got[4], 0);

        // Impulse on even slot.
        restart();
        send(65536);
        for (int i = 0; i < 7; i++) send(0);
        idle(8);
        pat_b = '{0, 32768, 0, 0};
        check("imp_even_cnt", got.size(), 4);
        for (int i = 0; i < 4; i++) check("imp_even", got[i], pat_b[i]);

        // DC gain.
        restart();
        for (int i = 0; i < 16; i++) send(10000);
        idle(8);
        for (int i = 4; i < 8; i++) check("dc_pos", got[i], 9968);
        restart();
        for (int i = 0; i < 16; i++) send(-131072);
        idle(8);
        check("dc_neg", got[7], -130656);

        // Saturation, both signs.
        restart();
        satp = '{0, -131072, 0, 131071, 131071, 131071, 0, -131072};
        for (int i = 0; i < 8; i++) send(satp[i]);
        idle(8);
        check("sat_pos", got[3], 131071);
        restart();
        satp = '{0, 131071, 0, -131072, -131072, -131072, 0, 131071};
        for (int i = 0; i < 8; i++) send(satp[i]);
        idle(8);
        check("sat_neg", got[3], -131072);

        // run dropped mid-computation: nothing emitted, state flushed.
        restart();
        send(5000); step(1'b1, 7000); step(1'b0, 0); step(1'b0, 0);
        run = 1'b0; step(1'b0, 0); run = 1'b1;
        idle(8);
        check("run_drop_cnt", got.size(), 0);
        for (int i = 0; i < 8; i++) send(0);
        idle(8);
        check("run_drop_zero", got[3], 0);

        // Bypass.
        restart();
        bypass = 1'b1;
        got.delete();
        send(1234); send(-777); send(1234);
        check("byp_cnt", got.size(), 3);
        check("byp_0", got[0], 1234);
        check("byp_1", got[1], -777);
        bypass = 1'b0;
        step(1'b0, 0);

        // Back-to-back strobe pair, then recovery on constant input.
        restart();
        for (int i = 0; i < 8; i++) send(10000);
        step(1'b1, 10000); step(1'b1, 10000); step(1'b0, 0);
        got.delete();
        for (int i = 0; i < 16; i++) send(10000);
        idle(8);
        check("recover", got[7], 9968);

        // Randomized traffic with extremes, run/bypass disturbances.
        restart();
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            r = W'($urandom);
            x = int'(r);
            if (sel == 0) x = 131071;
            if (sel == 1) x = -131072;
            step(1'b1, x);
            idle($urandom_range(1, 3));
            if ($urandom_range(0, 39) == 0) begin
                run = 1'b0; step(1'b0, 0); run = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) begin
                bypass = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    r = W'($urandom);
                    step(1'b1, int'(r));
                    step(1'b0, 0);
                end
                bypass = 1'b0;
            end
        end

        // Reset mid-run.
        restart();
        for (int i = 0; i < 10; i++) send(10000);
        step(1'b1, 10000);
        rst = 1'b1;
        step(1'b0, 0);
        check("rst_stb", longint'(stb_out), 0);
        check("rst_dout", longint'(data_out), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) send(3000);
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
